// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces a single
// pressed key, emits one coded pulse per press and tracks the key until released.
//
// state        | meaning
// SCAN         | rotate the driven column, sample rows on the last dwell cycle
// DEBOUNCE     | hold the column, count stable samples of the latched row pattern
// EMIT         | one-cycle data_valid pulse with the key code
// WAIT_RELEASE | hold the column, count stable all-high samples before rescanning
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       data_valid,
  output logic [3:0] digit,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync_q, rows_s;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [3:0]       digit_q, digit_d;
  logic             row_hit;
  logic [1:0]       row_idx;
  logic [3:0]       row_pat;
  logic [DEB_W-1:0] deb_inc;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Synchronizer flops reset high so an idle keypad reads as no key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      sync_q <= row_in;
      rows_s <= sync_q;
    end
  end

  // Only a single low row is a valid key; multiple rows are ambiguous.
  always_comb begin
    row_hit = 1'b1;
    row_idx = 2'd0;
    case (rows_s)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_hit = 1'b0;
    endcase
  end

  assign row_pat = ~(4'b0001 << row_q);
  assign deb_inc = (deb_q == DEB_MAX) ? deb_q : deb_q + DEB_W'(1);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    div_d   = div_q;
    deb_d   = deb_q;
    digit_d = digit_q;
    case (state_q)
      SCAN: begin
        if (div_q == '0) begin
          div_d = DIV_LOAD;
          if (row_hit) begin
            row_d   = row_idx;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      DEBOUNCE: begin
        if (rows_s == row_pat) begin
          deb_d = deb_inc;
          if (deb_q == DEB_LAST) begin
            state_d = EMIT;
            digit_d = key_code(row_q, col_q);
          end
        end else begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          div_d   = DIV_LOAD;
        end
      end
      EMIT: begin
        deb_d   = '0;
        state_d = WAIT_RELEASE;
      end
      default: begin
        if (rows_s == 4'hF) begin
          deb_d = deb_inc;
          if (deb_q == DEB_LAST) begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
            div_d   = DIV_LOAD;
          end
        end else begin
          deb_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      div_q   <= DIV_LOAD;
      deb_q   <= '0;
      digit_q <= 4'h0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      div_q   <= div_d;
      deb_q   <= deb_d;
      digit_q <= digit_d;
    end
  end

  // Outputs decode directly from registers so reset forces them immediately.
  assign col_out    = ~(4'b0001 << col_q);
  assign data_valid = (state_q == EMIT);
  assign key_held   = (state_q == EMIT) || (state_q == WAIT_RELEASE);
  assign digit      = digit_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized keypad presses against a matrix model; pulses are
// collected and compared with the key-code table.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       data_valid;
  logic [3:0] digit;
  logic       key_held;

  logic [3:0] pressed [4];
  logic       glitch;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;
  logic prev_dv = 1'b0;
  logic [3:0] last_digit = 4'h0;
  logic [3:0] got_q [$];
  logic [3:0] exp_q [$];
  logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .row_in     (row_in),
    .col_out    (col_out),
    .data_valid (data_valid),
    .digit      (digit),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A row reads low when a pressed key connects it to a column driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col_out[c]) row_in[r] = 1'b0;
    if (glitch) row_in = 4'hF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      check("col_one_low", 32'($countones(~col_out)), 1);
      if (data_valid) begin
        check("dv_not_consecutive", prev_dv, 0);
        check("held_at_pulse", key_held, 1);
        got_q.push_back(digit);
        last_digit = digit;
        pulse_cnt++;
      end
      prev_dv = data_valid;
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
  endtask

  task automatic wait_pulse(input string tag, input int limit);
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < limit && pulse_cnt == p0; i++) tick(1);
    check(tag, pulse_cnt - p0, 1);
  endtask

  initial begin
    int p0, base, cnt, idx, held_ok;
    logic found;
    int seq_keys [8] = '{0, 1, 2, 4, 5, 6, 8, 9};

    reset = 1'b1;
    glitch = 1'b0;
    clear_keys();
    repeat (3) @(negedge clk);
    check("rst_col", col_out, 4'b1110);
    check("rst_dv", data_valid, 0);
    check("rst_digit", digit, 4'h0);
    check("rst_held", key_held, 0);
    reset = 1'b0;
    tick(10);

    // row1/col2 held 200 cycles
    p0 = pulse_cnt;
    pressed[1][2] = 1'b1;
    tick(200);
    check("k6_pulses", pulse_cnt - p0, 1);
    check("k6_digit", last_digit, 4'h6);
    check("k6_held", key_held, 1);
    exp_pulses += 1;
    clear_keys();
    tick(6);
    check("k6_held_after_release", key_held, 1);
    tick(14);
    check("k6_released", key_held, 0);
    tick(20);

    // row3/col0 with a glitch during debounce
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (col_out == 4'b0111) found = 1'b1;
    end
    check("glitch_seek_col3", found, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (col_out == 4'b1110) found = 1'b1;
    end
    check("glitch_seek_col0", found, 1);
    pressed[3][0] = 1'b1;
    cnt = 1;
    for (int i = 0; i < 20 && cnt < 9; i++) begin
      tick(1);
      if (col_out == 4'b1110) cnt++;
      else break;
    end
    check("glitch_dwell", cnt, 9);
    p0 = pulse_cnt;
    glitch = 1'b1;
    tick(3);
    glitch = 1'b0;
    tick(2);
    check("glitch_no_pulse", pulse_cnt - p0, 0);
    tick(100);
    check("glitch_retry_pulses", pulse_cnt - p0, 1);
    check("glitch_retry_digit", last_digit, 4'h0);
    exp_pulses += 1;
    clear_keys();
    tick(30);

    // two rows low on one column
    p0 = pulse_cnt;
    pressed[0][1] = 1'b1;
    pressed[2][1] = 1'b1;
    tick(200);
    check("dual_row_no_pulse", pulse_cnt - p0, 0);
    clear_keys();
    tick(30);

    // digits 1..8 with randomized hold and release times
    base = got_q.size();
    for (int k = 0; k < 8; k++) begin
      idx = seq_keys[k];
      pressed[idx / 4][idx % 4] = 1'b1;
      tick($urandom_range(100, 60));
      clear_keys();
      tick($urandom_range(60, 40));
    end
    exp_pulses += 8;
    check("seq_count", got_q.size() - base, 8);
    for (int k = 0; k < 8; k++)
      if (base + k < got_q.size()) check("seq_digit", got_q[base + k], k + 1);

    // random keys
    base = got_q.size();
    exp_q.delete();
    for (int k = 0; k < 6; k++) begin
      idx = $urandom_range(15);
      exp_q.push_back(code_tab[idx]);
      pressed[idx / 4][idx % 4] = 1'b1;
      tick($urandom_range(100, 60));
      clear_keys();
      tick($urandom_range(60, 40));
    end
    exp_pulses += 6;
    check("rand_count", got_q.size() - base, 6);
    for (int k = 0; k < 6; k++)
      if (base + k < got_q.size()) check("rand_digit", got_q[base + k], exp_q[k]);

    // reset while the key is still held in WAIT_RELEASE
    pressed[2][0] = 1'b1;
    wait_pulse("rst_wr_first_pulse", 80);
    check("rst_wr_first_digit", last_digit, 4'h7);
    exp_pulses += 1;
    tick(5);
    check("rst_wr_held_before", key_held, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_wr_col", col_out, 4'b1110);
    check("rst_wr_dv", data_valid, 0);
    check("rst_wr_digit", digit, 4'h0);
    check("rst_wr_held", key_held, 0);
    tick(3);
    clear_keys();
    tick(3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wr_restart_col", col_out, 4'b1110);
    p0 = pulse_cnt;
    tick(100);
    check("rst_wr_no_spurious", pulse_cnt - p0, 0);
    pressed[2][0] = 1'b1;
    tick(80);
    check("rst_wr_new_pulses", pulse_cnt - p0, 1);
    check("rst_wr_new_digit", last_digit, 4'h7);
    exp_pulses += 1;
    clear_keys();
    tick(30);

    // long hold of row2/col3
    p0 = pulse_cnt;
    pressed[2][3] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 80 && pulse_cnt == p0; i++) begin
      tick(1);
      cnt++;
    end
    held_ok = 1;
    for (int i = cnt; i < 1000; i++) begin
      tick(1);
      if (!key_held) held_ok = 0;
    end
    check("long_pulses", pulse_cnt - p0, 1);
    check("long_digit", last_digit, 4'hC);
    check("long_held_throughout", held_ok, 1);
    exp_pulses += 1;
    clear_keys();
    tick(30);
    check("long_released", key_held, 0);

    check("total_pulses", pulse_cnt, exp_pulses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
